// File: rtl/queue_status_fifo.sv
// Synchronous FIFO with fill count, almost flags, sticky error flags,
// synchronous flush and optional first-word-fall-through read mode.
module queue_status_fifo #(
    parameter int data_width         = 8,
    parameter int address_width      = 4,
    parameter int almost_full_level  = 12,
    parameter int almost_empty_level = 2,
    parameter int fwft               = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write_cmd,
    input  logic [data_width-1:0]    write_data,
    input  logic                     read_cmd,
    input  logic                     flush,
    input  logic                     clear_err,
    output logic [data_width-1:0]    read_data,
    output logic                     read_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [address_width:0]   fill_count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int DEPTH = 2 ** address_width;
    localparam int CW    = address_width + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(almost_full_level);
    localparam logic [CW-1:0] AE_C    = CW'(almost_empty_level);

    logic [data_width-1:0]    mem [DEPTH];

    logic [address_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [address_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     full_q, full_d;
    logic                     empty_q, empty_d;
    logic                     afull_q, afull_d;
    logic                     aempty_q, aempty_d;
    logic                     ovf_q, ovf_d;
    logic                     unf_q, unf_d;
    logic [data_width-1:0]    rdata_q, rdata_d;
    logic                     rvalid_q, rvalid_d;

    logic rd_acc;
    logic wr_acc;

    // A read needs stored data; a write into a full queue needs a read to make room.
    assign rd_acc = read_cmd & ~empty_q;
    assign wr_acc = write_cmd & (~full_q | rd_acc);

    // Next-state: pointers, fill count, registered flags, read register and errors.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + address_width'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + address_width'(1);
                rdata_d  = mem[rd_ptr_q];
                rvalid_d = 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + CW'(1);
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - CW'(1);
            end
        end
        full_d   = (count_d == DEPTH_C);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AF_C);
        aempty_d = (count_d <= AE_C);
        // A new error event wins over a simultaneous clear.
        ovf_d = (ovf_q & ~clear_err) | (write_cmd & full_q & ~rd_acc);
        unf_d = (unf_q & ~clear_err) | (read_cmd & empty_q);
    end

    // State registers; reset empties the queue and clears every flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush) begin
            mem[wr_ptr_q] <= write_data;
        end
    end

    generate
        if (fwft != 0) begin : g_fwft
            // Head word is shown directly; last popped word is held while empty.
            assign read_data  = empty_q ? rdata_q : mem[rd_ptr_q];
            assign read_valid = ~empty_q;
        end else begin : g_reg
            assign read_data  = rdata_q;
            assign read_valid = rvalid_q;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign fill_count   = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
